ble_rx_dma: RTL and testbench

- Sits between the BLE uart_rx and servant_ram, and shares the RAM Wishbone port with the SERV CPU.
- Buffers received bytes in a small FIFO and writes each byte into a circular RAM window at consecutive byte addresses.
- Arbitrates the single RAM port between the CPU and the DMA path without dropping or corrupting CPU cycles.
- Replaces the ad-hoc recieve-mux in the top level.

---
 rtl/ble_dma_pkg.sv | 18 +
 rtl/ble_rx_fifo.sv | 49 ++++
 rtl/ble_rx_dma.sv | 129 ++++++++++++
 tb/tb_ble_rx_dma.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_dma_pkg.sv
// Shared types and helpers for the BLE RX DMA path: arbiter states,
// grant encodings and the byte-lane select used for RAM byte writes.
package ble_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } arb_state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/ble_rx_fifo.sv
// Small synchronous byte FIFO with first-word-fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ble_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty_c = (level == '0);
  assign full_c  = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign head_c  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ble_rx_dma.sv
// Buffers uart_rx bytes and writes them into a circular RAM window,
// sharing the single RAM Wishbone port with the CPU (round-robin arbiter).
module ble_rx_dma
  import ble_dma_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_1000,
  parameter logic [31:0] SIZE       = 32'h0000_0800,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_wb_clk,
  input  logic                          i_wb_rst,
  input  logic                          i_rx_valid,
  input  logic [7:0]                    i_rx_data,
  input  logic [31:0]                   i_wb_cpu_adr,
  input  logic                          i_wb_cpu_cyc,
  input  logic                          i_wb_cpu_we,
  input  logic [3:0]                    i_wb_cpu_sel,
  input  logic [31:0]                   i_wb_cpu_dat,
  output logic [31:0]                   o_wb_cpu_rdt,
  output logic                          o_wb_cpu_ack,
  output logic [31:0]                   o_wb_mem_adr,
  output logic                          o_wb_mem_cyc,
  output logic                          o_wb_mem_we,
  output logic [3:0]                    o_wb_mem_sel,
  output logic [31:0]                   o_wb_mem_dat,
  input  logic [31:0]                   i_wb_mem_rdt,
  input  logic                          i_wb_mem_ack,
  output logic [31:0]                   o_wr_ptr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow
);

  localparam int unsigned OW = $clog2(SIZE);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic          last_gnt;
  logic [OW-1:0] offset;
  logic [31:0]   dma_adr;
  logic [3:0]    dma_sel;
  logic [31:0]   dma_dat;
  logic [7:0]    fifo_head_c;
  logic          fifo_full_c;
  logic          fifo_empty_c;
  logic          fifo_pop;
  logic          grant_dma;

  assign fifo_pop     = (state == ST_DMA) && i_wb_mem_ack;
  assign o_wr_ptr     = BASE + 32'(offset);
  assign o_wb_cpu_rdt = i_wb_mem_rdt;
  assign grant_dma    = (state == ST_IDLE) && (state_nxt == ST_DMA);

  ble_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_wb_clk),
    .rst     (i_wb_rst),
    .push    (i_rx_valid),
    .din     (i_rx_data),
    .pop     (fifo_pop),
    .head_c  (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level   (o_fifo_level)
  );

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and RAM port mux; IDLE always sits between two grants
  always_comb begin
    state_nxt    = state;
    o_wb_mem_adr = '0;
    o_wb_mem_cyc = 1'b0;
    o_wb_mem_we  = 1'b0;
    o_wb_mem_sel = '0;
    o_wb_mem_dat = '0;
    o_wb_cpu_ack = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_wb_cpu_cyc && (fifo_empty_c || last_gnt == GNT_DMA)) state_nxt = ST_CPU;
        else if (!fifo_empty_c)                                     state_nxt = ST_DMA;
      end
      ST_CPU: begin
        o_wb_mem_adr = i_wb_cpu_adr;
        o_wb_mem_cyc = i_wb_cpu_cyc;
        o_wb_mem_we  = i_wb_cpu_we;
        o_wb_mem_sel = i_wb_cpu_sel;
        o_wb_mem_dat = i_wb_cpu_dat;
        o_wb_cpu_ack = i_wb_mem_ack;
        if (i_wb_mem_ack || !i_wb_cpu_cyc) state_nxt = ST_IDLE;
      end
      ST_DMA: begin
        o_wb_mem_adr = dma_adr;
        o_wb_mem_cyc = 1'b1;
        o_wb_mem_we  = 1'b1;
        o_wb_mem_sel = dma_sel;
        o_wb_mem_dat = dma_dat;
        if (i_wb_mem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant history, DMA request registers, window pointer and overflow flag
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      last_gnt   <= GNT_DMA;
      offset     <= '0;
      dma_adr    <= '0;
      dma_sel    <= '0;
      dma_dat    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_CPU) last_gnt <= GNT_CPU;
      if (grant_dma) begin
        last_gnt <= GNT_DMA;
        dma_adr  <= o_wr_ptr;
        dma_sel  <= lane_sel(o_wr_ptr[1:0]);
        dma_dat  <= {4{fifo_head_c}};
      end
      if (fifo_pop) offset <= offset + OW'(1);
      if (i_rx_valid && fifo_full_c && !fifo_pop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ble_rx_dma.sv
// Self-checking bench for ble_rx_dma: directed table, corner sequences and
// randomized traffic against a queue-based model of the RX window writer.
module tb_ble_rx_dma;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SIZE  = 32'h0000_0800;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [31:0] cpu_adr = '0;
  logic        cpu_cyc = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_sel = '0;
  logic [31:0] cpu_dat = '0;
  logic [31:0] cpu_rdt;
  logic        cpu_ack;
  logic [31:0] mem_adr;
  logic        mem_cyc;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_dat;
  logic [31:0] mem_rdt = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] wr_ptr;
  logic [2:0]  fifo_level;
  logic        overflow;

  ble_rx_dma #(.BASE(BASE), .SIZE(SIZE), .FIFO_DEPTH(DEPTH)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_cyc(cpu_cyc), .i_wb_cpu_we(cpu_we),
    .i_wb_cpu_sel(cpu_sel), .i_wb_cpu_dat(cpu_dat), .o_wb_cpu_rdt(cpu_rdt),
    .o_wb_cpu_ack(cpu_ack), .o_wb_mem_adr(mem_adr), .o_wb_mem_cyc(mem_cyc),
    .o_wb_mem_we(mem_we), .o_wb_mem_sel(mem_sel), .o_wb_mem_dat(mem_dat),
    .i_wb_mem_rdt(mem_rdt), .i_wb_mem_ack(mem_ack), .o_wr_ptr(wr_ptr),
    .o_fifo_level(fifo_level), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // servant_ram-style responder: ack one cycle after cyc, cyc must drop in between
  logic ram_stall = 1'b0;
  always @(posedge clk) begin
    mem_ack <= !rst && mem_cyc && !mem_ack && !ram_stall;
    mem_rdt <= mem_adr ^ 32'h5A5A_A5A5;
  end

  // Reference model: bytes waiting for RAM, next window address, sticky drop flag
  logic [7:0]  q[$];
  logic [31:0] m_ptr = BASE;
  logic        m_ovf = 1'b0;
  logic        prev_ack = 1'b0;
  int          dma_writes = 0;
  int          cpu_ack_pulses = 0;
  logic [31:0] last_adr, last_sel, last_dat;
  logic [7:0]  dma_log[$];
  bit          kinds[$];
  bit          cpu_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_ptr    = BASE;
      m_ovf    = 1'b0;
      prev_ack = 1'b0;
      chk("rst_cyc", 32'(mem_cyc), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_wr_ptr", wr_ptr, BASE);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_overflow", 32'(overflow), 0);
    end else begin
      chk("wr_ptr", wr_ptr, m_ptr);
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("cpu_rdt", cpu_rdt, mem_rdt);
      if (prev_ack) chk("cyc_gap_after_ack", 32'(mem_cyc), 0);
      prev_ack = mem_ack;
      if (cpu_ack) cpu_ack_pulses++;
      if (mem_cyc && mem_ack) begin
        if (mem_adr >= BASE && mem_adr < BASE + SIZE) begin
          n_vec++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL dma_unexpected: write to %h, expected no pending byte", mem_adr);
          end else begin
            chk("dma_adr", mem_adr, m_ptr);
            chk("dma_we", 32'(mem_we), 1);
            chk("dma_sel", 32'(mem_sel), 32'(1) << (m_ptr % 32'd4));
            chk("dma_dat", mem_dat, 32'(q[0]) * 32'h0101_0101);
            chk("dma_cpu_ack", 32'(cpu_ack), 0);
            dma_log.push_back(q[0]);
            void'(q.pop_front());
            m_ptr = BASE + ((m_ptr - BASE + 1) % SIZE);
          end
          dma_writes++;
          last_adr = mem_adr;
          last_sel = 32'(mem_sel);
          last_dat = mem_dat;
          kinds.push_back(1'b1);
        end else begin
          chk("cpu_ack", 32'(cpu_ack), 1);
          chk("cpu_adr_pass", mem_adr, cpu_adr);
          chk("cpu_we_pass", 32'(mem_we), 32'(cpu_we));
          chk("cpu_sel_pass", 32'(mem_sel), 32'(cpu_sel));
          chk("cpu_dat_pass", mem_dat, cpu_dat);
          cpu_done = 1'b1;
          kinds.push_back(1'b0);
        end
      end else begin
        chk("cpu_ack_idle", 32'(cpu_ack), 0);
      end
      if (rx_valid) begin
        if (q.size() < DEPTH) q.push_back(rx_data);
        else                  m_ovf = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ram_stall = 1'b0;
    cpu_cyc = 1'b0;
    rx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_writes(input int n, input int budget);
    int t = 0;
    while (dma_writes < n && t < budget) begin
      tick();
      t++;
    end
    n_vec++;
    if (dma_writes < n) begin
      n_err++;
      $display("FAIL wait_writes: got %0d writes, expected %0d", dma_writes, n);
    end
  endtask

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] ptr;
  } vec_t;

  vec_t vt[4];
  int   base_w;
  int   t;
  int   cpu_wait;
  int   acks0;

  initial begin
    vt[0] = '{8'h41, 32'h0000_1000, 4'b0001, 32'h4141_4141, 32'h0000_1001};
    vt[1] = '{8'h42, 32'h0000_1001, 4'b0010, 32'h4242_4242, 32'h0000_1002};
    vt[2] = '{8'h43, 32'h0000_1002, 4'b0100, 32'h4343_4343, 32'h0000_1003};
    vt[3] = '{8'h44, 32'h0000_1003, 4'b1000, 32'h4444_4444, 32'h0000_1004};

    // Four bytes, no CPU traffic
    do_reset();
    for (int i = 0; i < 4; i++) begin
      base_w = dma_writes;
      push_byte(vt[i].data);
      wait_writes(base_w + 1, 20);
      chk("t1_adr", last_adr, vt[i].adr);
      chk("t1_sel", last_sel, 32'(vt[i].sel));
      chk("t1_dat", last_dat, vt[i].dat);
      chk("t1_wr_ptr", wr_ptr, vt[i].ptr);
    end

    // Window wrap after SIZE bytes
    do_reset();
    base_w = dma_writes;
    for (int i = 0; i < 2049; i++) begin
      push_byte(8'($urandom));
      tick();
      tick();
      tick();
    end
    wait_writes(base_w + 2049, 20);
    chk("t2_wrap_adr", last_adr, BASE);
    chk("t2_wrap_ptr", wr_ptr, BASE + 32'd1);

    // CPU holding cyc continuously while one byte arrives
    do_reset();
    kinds.delete();
    acks0 = cpu_ack_pulses;
    cpu_adr = 32'h0000_0100;
    cpu_we  = 1'b0;
    cpu_sel = 4'hF;
    cpu_dat = '0;
    cpu_cyc = 1'b1;
    push_byte(8'h77);
    t = 0;
    while (kinds.size() < 3 && t < 60) begin
      tick();
      t++;
    end
    cpu_cyc = 1'b0;
    chk("t3_txn_count", 32'(kinds.size() >= 3), 1);
    if (kinds.size() >= 3) begin
      chk("t3_first_cpu", 32'(kinds[0]), 0);
      chk("t3_then_dma", 32'(kinds[1]), 1);
      chk("t3_then_cpu", 32'(kinds[2]), 0);
    end
    tick();
    tick();
    chk("t3_cpu_acks", 32'(cpu_ack_pulses - acks0), 2);

    // Stalled RAM, five bytes into a four-entry FIFO
    do_reset();
    dma_log.delete();
    base_w = dma_writes;
    ram_stall = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
    tick();
    tick();
    chk("t4_level_full", 32'(fifo_level), 4);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_no_writes", 32'(dma_writes - base_w), 0);
    ram_stall = 1'b0;
    wait_writes(base_w + 4, 60);
    for (int i = 0; i < 20; i++) tick();
    chk("t4_write_count", 32'(dma_writes - base_w), 4);
    chk("t4_log_size", 32'(dma_log.size()), 4);
    if (dma_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t4_order", 32'(dma_log[i]), 32'h0000_00A0 + 32'(i));
    chk("t4_drained", 32'(fifo_level), 0);
    chk("t4_ovf_sticky", 32'(overflow), 1);

    // Push into a full FIFO in the same cycle as the DMA ack
    do_reset();
    dma_log.delete();
    base_w = dma_writes;
    ram_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i));
    tick();
    tick();
    chk("t5_full", 32'(fifo_level), 4);
    ram_stall = 1'b0;
    tick();
    chk("t5_ack_align", 32'(mem_ack), 1);
    push_byte(8'hB4);
    chk("t5_level_kept", 32'(fifo_level), 4);
    chk("t5_no_overflow", 32'(overflow), 0);
    wait_writes(base_w + 5, 60);
    if (dma_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("t5_order", 32'(dma_log[i]), 32'h0000_00B0 + 32'(i));

    // Reset in the middle of a stalled DMA cycle
    do_reset();
    base_w = dma_writes;
    push_byte(8'h11);
    push_byte(8'h22);
    wait_writes(base_w + 2, 30);
    ram_stall = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    tick();
    chk("t6_pre_cyc", 32'(mem_cyc), 1);
    chk("t6_pre_ovf", 32'(overflow), 1);
    rst = 1'b1;
    #1;
    chk("t6_cyc", 32'(mem_cyc), 0);
    chk("t6_wr_ptr", wr_ptr, BASE);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_overflow", 32'(overflow), 0);
    tick();
    ram_stall = 1'b0;
    rst = 1'b0;
    tick();

    // Randomized RX, RAM stalls and SERV-like CPU transactions
    do_reset();
    cpu_wait = 0;
    for (int c = 0; c < 4000; c++) begin
      rx_valid  = ($urandom_range(0, 3) == 0);
      rx_data   = 8'($urandom);
      ram_stall = ($urandom_range(0, 7) == 0);
      if (cpu_cyc) begin
        cpu_wait++;
        if (cpu_done) begin
          cpu_cyc = 1'b0;
          cpu_wait = 0;
        end else if (cpu_wait > 200) begin
          n_vec++;
          n_err++;
          $display("FAIL cpu_ack_timeout: no ack after %0d cycles, expected one", cpu_wait);
          cpu_cyc = 1'b0;
          cpu_wait = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_adr  = $urandom & 32'h0000_0FFC;
        cpu_we   = 1'($urandom);
        cpu_sel  = 4'($urandom);
        cpu_dat  = $urandom;
        cpu_done = 1'b0;
        cpu_cyc  = 1'b1;
      end
      tick();
    end
    rx_valid  = 1'b0;
    ram_stall = 1'b0;
    t = 0;
    while ((cpu_cyc || fifo_level != 0) && t < 300) begin
      if (cpu_cyc && cpu_done) cpu_cyc = 1'b0;
      tick();
      t++;
    end
    chk("drain_level", 32'(fifo_level), 0);
    chk("drain_cpu_idle", 32'(cpu_cyc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
